// File: rtl/ex_lsu_axi_pkg.sv
// Shared types and constants for the EX-stage load/store unit: FSM states,
// funct3 load/store encodings, access sizes and AXI response codes.
package ex_lsu_axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4,
    S_DONE    = 3'd5
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  function automatic logic [1:0] f3_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: f3_size = SIZE_B;
      F3_LH, F3_LHU: f3_size = SIZE_H;
      F3_LW, F3_LWU: f3_size = SIZE_W;
      default:       f3_size = SIZE_D;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      SIZE_H:  is_misaligned = off[0];
      SIZE_W:  is_misaligned = |off[1:0];
      SIZE_D:  is_misaligned = |off[2:0];
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_lsu_axi_lane.sv
// Byte-lane steering: store replication and strobe generation, and load
// right-shift followed by sign/zero extension.
module lsu_lane_align
  import ex_lsu_axi_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic [1:0]      i_st_size,
  input  logic [2:0]      i_st_off,
  input  logic [63:0]     i_st_data,
  output logic [DW-1:0]   o_st_wdata,
  output logic [DW/8-1:0] o_st_wstrb,
  input  logic [1:0]      i_ld_size,
  input  logic [2:0]      i_ld_off,
  input  logic            i_ld_uns,
  input  logic [DW-1:0]   i_ld_data,
  output logic [63:0]     o_ld_data
);

  logic [DW/8-1:0] w_strb_base;
  logic [DW-1:0]   w_shift;
  logic            w_sx;

  always_comb begin
    o_st_wdata  = i_st_data[DW-1:0];
    w_strb_base = '1;
    case (i_st_size)
      SIZE_B: begin
        o_st_wdata  = {(DW/8){i_st_data[7:0]}};
        w_strb_base = {{(DW/8-1){1'b0}}, 1'b1};
      end
      SIZE_H: begin
        o_st_wdata  = {(DW/16){i_st_data[15:0]}};
        w_strb_base = {{(DW/8-2){1'b0}}, 2'b11};
      end
      SIZE_W: begin
        o_st_wdata  = {(DW/32){i_st_data[31:0]}};
        w_strb_base = {{(DW/8-4){1'b0}}, 4'hF};
      end
      default: ;
    endcase
    o_st_wstrb = w_strb_base << i_st_off;
  end

  assign w_shift = i_ld_data >> {i_ld_off, 3'b000};

  // Sign bit is forced to zero for the unsigned variants.
  always_comb begin
    o_ld_data = w_shift[63:0];
    w_sx      = 1'b0;
    case (i_ld_size)
      SIZE_B: begin
        w_sx      = ~i_ld_uns & w_shift[7];
        o_ld_data = {{56{w_sx}}, w_shift[7:0]};
      end
      SIZE_H: begin
        w_sx      = ~i_ld_uns & w_shift[15];
        o_ld_data = {{48{w_sx}}, w_shift[15:0]};
      end
      SIZE_W: begin
        w_sx      = ~i_ld_uns & w_shift[31];
        o_ld_data = {{32{w_sx}}, w_shift[31:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_lsu_axi.sv
// EX-stage load/store unit: one AXI4-Lite transaction per memory instruction,
// stalling the pipeline through hold_req_o until the access retires in DONE.
module ex_lsu_axi
  import ex_lsu_axi_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst_i,
  input  logic [63:0]     base_addr_i,
  input  logic [63:0]     addr_offset_i,
  input  logic [63:0]     op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            read_ram_i,
  input  logic            write_ram_i,
  output logic            hold_req_o,
  output logic            mem_wen_o,
  output logic [4:0]      mem_waddr_o,
  output logic [63:0]     mem_wdata_o,
  output logic            bus_err_o,
  output logic [AW-1:0]   m_araddr_o,
  output logic            m_arvalid_o,
  input  logic            m_arready_i,
  input  logic [DW-1:0]   m_rdata_i,
  input  logic [1:0]      m_rresp_i,
  input  logic            m_rvalid_i,
  output logic            m_rready_o,
  output logic [AW-1:0]   m_awaddr_o,
  output logic            m_awvalid_o,
  input  logic            m_awready_i,
  output logic [DW-1:0]   m_wdata_o,
  output logic [DW/8-1:0] m_wstrb_o,
  output logic            m_wvalid_o,
  input  logic            m_wready_i,
  input  logic [1:0]      m_bresp_i,
  input  logic            m_bvalid_i,
  output logic            m_bready_o,
  output lsu_state_t      dbg_state_o
);

  lsu_state_t      r_state, w_state_n;
  logic [AW-1:0]   r_addr;
  logic [1:0]      r_size;
  logic            r_uns;
  logic            r_is_load;
  logic            r_misal;
  logic [4:0]      r_rd;
  logic [DW-1:0]   r_wdata;
  logic [DW/8-1:0] r_wstrb;
  logic [DW-1:0]   r_rdata;
  logic [1:0]      r_resp;
  logic            r_aw_done;
  logic            r_w_done;

  logic [2:0]      w_funct3;
  logic [63:0]     w_ea;
  logic [1:0]      w_size;
  logic            w_uns;
  logic            w_req;
  logic            w_misal;
  logic [DW-1:0]   w_st_wdata;
  logic [DW/8-1:0] w_st_wstrb;
  logic [63:0]     w_ld_data;
  logic            w_aw_done_n;
  logic            w_w_done_n;
  logic            w_unused;

  assign w_funct3 = inst_i[14:12];
  assign w_ea     = base_addr_i + addr_offset_i;
  assign w_size   = f3_size(w_funct3);
  assign w_uns    = w_funct3[2];
  assign w_req    = read_ram_i | write_ram_i;
  assign w_misal  = is_misaligned(w_size, w_ea[2:0]);
  assign w_unused = ^{inst_i[31:15], inst_i[11:0], w_ea[63:AW]};

  lsu_lane_align #(.DW(DW)) u_lane (
    .i_st_size  (w_size),
    .i_st_off   (w_ea[2:0]),
    .i_st_data  (op2_i),
    .o_st_wdata (w_st_wdata),
    .o_st_wstrb (w_st_wstrb),
    .i_ld_size  (r_size),
    .i_ld_off   (r_addr[2:0]),
    .i_ld_uns   (r_uns),
    .i_ld_data  (r_rdata),
    .o_ld_data  (w_ld_data)
  );

  // Handshake: a valid is raised on entry to its state and held until the
  // matching ready is sampled high on a rising edge; payload registers are
  // only written in IDLE, so address/data stay stable while any valid is up.
  always_comb begin
    w_state_n   = r_state;
    w_aw_done_n = r_aw_done;
    w_w_done_n  = r_w_done;
    hold_req_o  = 1'b0;
    m_arvalid_o = 1'b0;
    m_rready_o  = 1'b0;
    m_awvalid_o = 1'b0;
    m_wvalid_o  = 1'b0;
    m_bready_o  = 1'b0;
    mem_wen_o   = 1'b0;
    bus_err_o   = 1'b0;
    case (r_state)
      S_IDLE: begin
        hold_req_o = w_req;
        if (w_req) begin
          if (w_misal)         w_state_n = S_DONE;
          else if (read_ram_i) w_state_n = S_RD_ADDR;
          else                 w_state_n = S_WR_REQ;
        end
      end
      S_RD_ADDR: begin
        hold_req_o  = 1'b1;
        m_arvalid_o = 1'b1;
        if (m_arready_i) w_state_n = S_RD_DATA;
      end
      S_RD_DATA: begin
        hold_req_o = 1'b1;
        m_rready_o = 1'b1;
        if (m_rvalid_i) w_state_n = S_DONE;
      end
      S_WR_REQ: begin
        hold_req_o  = 1'b1;
        m_awvalid_o = ~r_aw_done;
        m_wvalid_o  = ~r_w_done;
        w_aw_done_n = r_aw_done | (m_awvalid_o & m_awready_i);
        w_w_done_n  = r_w_done | (m_wvalid_o & m_wready_i);
        if (w_aw_done_n && w_w_done_n) w_state_n = S_WR_RESP;
      end
      S_WR_RESP: begin
        hold_req_o = 1'b1;
        m_bready_o = 1'b1;
        if (m_bvalid_i) w_state_n = S_DONE;
      end
      S_DONE: begin
        w_state_n = S_IDLE;
        mem_wen_o = r_is_load & ~r_misal & (r_resp == RESP_OKAY) & (r_rd != 5'd0);
        bus_err_o = r_misal | (r_resp != RESP_OKAY);
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_size    <= SIZE_B;
      r_uns     <= 1'b0;
      r_is_load <= 1'b0;
      r_misal   <= 1'b0;
      r_rd      <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_resp    <= RESP_OKAY;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_aw_done <= w_aw_done_n;
      r_w_done  <= w_w_done_n;
      if (r_state == S_IDLE && w_req) begin
        r_addr    <= w_ea[AW-1:0];
        r_size    <= w_size;
        r_uns     <= w_uns;
        r_is_load <= read_ram_i;
        r_misal   <= w_misal;
        r_rd      <= rd_addr_i;
        r_wdata   <= w_st_wdata;
        r_wstrb   <= w_st_wstrb;
        r_resp    <= RESP_OKAY;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (r_state == S_RD_DATA && m_rvalid_i) begin
        r_rdata <= m_rdata_i;
        r_resp  <= m_rresp_i;
      end
      if (r_state == S_WR_RESP && m_bvalid_i) r_resp <= m_bresp_i;
    end
  end

  assign m_araddr_o  = r_addr;
  assign m_awaddr_o  = r_addr;
  assign m_wdata_o   = r_wdata;
  assign m_wstrb_o   = r_wstrb;
  assign mem_waddr_o = r_rd;
  assign mem_wdata_o = w_ld_data;
  assign dbg_state_o = r_state;

endmodule
